// File: rtl/fpro_keycode_in_fifo.sv
// Keycode receive FIFO with an Avalon-MM register front end (DATA/STATUS/CONTROL/DROPS)
// and a level interrupt for pending keycodes or overflow.
module fpro_keycode_in_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_code,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   head, tail, head_next, tail_next, count;
  logic              overflow, overflow_next, irq_en, irq_en_next;
  logic [15:0]       drop_cnt, drop_cnt_next;
  logic              empty, full, wr, pop, push, drop, flush, ctrl_wr;
  logic              unused_wdata;

  assign unused_wdata = ^writedata[31:3];

  assign empty = (head == tail);
  assign full  = (head[ADDR_W] != tail[ADDR_W]) && (head[ADDR_W-1:0] == tail[ADDR_W-1:0]);
  assign count = tail - head;

  always_comb begin
    wr      = chipselect & ~write_n;
    ctrl_wr = wr & (address == 2'd2);
    flush   = ctrl_wr & writedata[1];
    pop     = chipselect & read & (address == 2'd0) & ~empty;
    // flush discards any same-cycle push and does not count it as a drop
    push    = key_valid & (~full | pop) & ~flush;
    drop    = key_valid & full & ~pop & ~flush;

    head_next = head;
    tail_next = tail;
    if (flush) begin
      head_next = '0;
      tail_next = '0;
    end else begin
      if (pop)  head_next = head + PTR_ONE;
      if (push) tail_next = tail + PTR_ONE;
    end

    // a new drop beats a same-cycle clear for both overflow and drop_cnt
    overflow_next = drop | (overflow & ~(wr & (address == 2'd1) & writedata[2]));

    drop_cnt_next = drop_cnt;
    if (wr && address == 2'd3)
      drop_cnt_next = {15'd0, drop};
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt_next = drop_cnt + 16'd1;

    irq_en_next = ctrl_wr ? writedata[0] : irq_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      head     <= head_next;
      tail     <= tail_next;
      overflow <= overflow_next;
      drop_cnt <= drop_cnt_next;
      irq_en   <= irq_en_next;
      irq      <= irq_en_next & ((head_next != tail_next) | overflow_next);
    end
  end

  // storage has no reset; contents past the pointers are don't-care
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[tail[ADDR_W-1:0]] <= key_code;
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[31] = empty;
        if (!empty) readdata[DATA_W-1:0] = mem[head[ADDR_W-1:0]];
      end
      2'd1: begin
        readdata[0]          = empty;
        readdata[1]          = full;
        readdata[2]          = overflow;
        readdata[ADDR_W+8:8] = count;
      end
      2'd2: readdata[0] = irq_en;
      default: readdata[15:0] = drop_cnt;
    endcase
  end

endmodule

// File: tb/tb_fpro_keycode_in_fifo.sv
// Directed bench for fpro_keycode_in_fifo: register map, FIFO ordering, overflow/drops,
// push-while-full-with-pop, irq timing, flush and mid-fill reset.
module tb_fpro_keycode_in_fifo;

  logic        clk = 1'b0;
  logic        reset, key_valid, chipselect, read, write_n;
  logic [7:0]  key_code;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        irq;
  int          tests = 0;
  int          fails = 0;

  fpro_keycode_in_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .address(address), .chipselect(chipselect), .read(read), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // inputs change 1ns after the rising edge; readdata is sampled before the next edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    key_valid = 0; chipselect = 0; read = 0; write_n = 1; address = 0; writedata = 0;
  endtask

  task automatic push(input logic [7:0] code);
    key_valid = 1; key_code = code;
    tick();
    key_valid = 0;
  endtask

  // optional same-cycle push alongside the register access
  task automatic rd(input logic [1:0] a, input bit kv, input logic [7:0] code,
                    output logic [31:0] d);
    chipselect = 1; read = 1; address = a; key_valid = kv; key_code = code;
    #1 d = readdata;
    tick();
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v, input bit kv,
                    input logic [7:0] code);
    chipselect = 1; write_n = 0; address = a; writedata = v; key_valid = kv; key_code = code;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1; tick(); tick(); reset = 0;
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1) begin $display("FAIL reset_status got %h exp %h", d, 32'h1); fails++; end
    rd(2'd0, 0, 0, d); tests++;
    if (d !== 32'h8000_0000) begin $display("FAIL reset_data got %h exp %h", d, 32'h8000_0000); fails++; end
    rd(2'd2, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL reset_ctrl got %h exp 0", d); fails++; end
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL reset_drops got %h exp 0", d); fails++; end
    tests++;
    if (irq !== 1'b0) begin $display("FAIL reset_irq got %b exp 0", irq); fails++; end
  endtask

  task automatic test_order();
    logic [31:0] d;
    logic [7:0] exp [3];
    exp = '{8'h1C, 8'h32, 8'h21};
    for (int i = 0; i < 3; i++) push(exp[i]);
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h300) begin $display("FAIL order_count got %h exp %h", d, 32'h300); fails++; end
    for (int i = 0; i < 3; i++) begin
      rd(2'd0, 0, 0, d); tests++;
      if (d !== {24'h0, exp[i]}) begin $display("FAIL order_pop%0d got %h exp %h", i, d, exp[i]); fails++; end
    end
    rd(2'd0, 0, 0, d); tests++;
    if (d !== 32'h8000_0000) begin $display("FAIL order_empty got %h exp %h", d, 32'h8000_0000); fails++; end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    push(8'hAA); push(8'hAA);
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1006) begin $display("FAIL ovf_status got %h exp %h", d, 32'h1006); fails++; end
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h2) begin $display("FAIL ovf_drops got %h exp 2", d); fails++; end
    wr(2'd1, 32'h4, 0, 0);
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1002) begin $display("FAIL ovf_clear got %h exp %h", d, 32'h1002); fails++; end
    wr(2'd3, 32'h0, 0, 0);
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL drops_clear got %h exp 0", d); fails++; end
  endtask

  // FIFO holds 0x10..0x1F here
  task automatic test_full_pushpop();
    logic [31:0] d;
    rd(2'd0, 1, 8'h55, d); tests++;
    if (d !== 32'h10) begin $display("FAIL fullpp_head got %h exp 10", d); fails++; end
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1002) begin $display("FAIL fullpp_status got %h exp %h", d, 32'h1002); fails++; end
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL fullpp_drops got %h exp 0", d); fails++; end
    for (int i = 1; i < 16; i++) begin
      rd(2'd0, 0, 0, d); tests++;
      if (d !== 32'h10 + i) begin $display("FAIL fullpp_drain%0d got %h exp %h", i, d, 32'h10 + i); fails++; end
    end
    rd(2'd0, 0, 0, d); tests++;
    if (d !== 32'h55) begin $display("FAIL fullpp_last got %h exp 55", d); fails++; end
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1) begin $display("FAIL fullpp_empty got %h exp 1", d); fails++; end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(2'd2, 32'h1, 0, 0); tests++;
    if (irq !== 1'b0) begin $display("FAIL irq_idle got %b exp 0", irq); fails++; end
    push(8'h5A); tests++;
    if (irq !== 1'b1) begin $display("FAIL irq_rise got %b exp 1", irq); fails++; end
    rd(2'd0, 0, 0, d); tests++;
    if (d !== 32'h5A) begin $display("FAIL irq_pop got %h exp 5a", d); fails++; end
    tests++;
    if (irq !== 1'b0) begin $display("FAIL irq_fall got %b exp 0", irq); fails++; end
    push(8'h01); push(8'h02); tests++;
    if (irq !== 1'b1) begin $display("FAIL irq_pending got %b exp 1", irq); fails++; end
    wr(2'd2, 32'h0, 0, 0); tests++;
    if (irq !== 1'b0) begin $display("FAIL irq_disable got %b exp 0", irq); fails++; end
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h200) begin $display("FAIL irq_count got %h exp %h", d, 32'h200); fails++; end
  endtask

  // two entries already queued; flush with a concurrent push
  task automatic test_flush();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
    wr(2'd2, 32'h2, 1, 8'h99);
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1) begin $display("FAIL flush_status got %h exp 1", d); fails++; end
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL flush_drops got %h exp 0", d); fails++; end
    rd(2'd2, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL flush_ctrl got %h exp 0", d); fails++; end
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    rd(2'd0, 1, 8'h77, d); tests++;
    if (d !== 32'h8000_0000) begin $display("FAIL empty_pp_data got %h exp %h", d, 32'h8000_0000); fails++; end
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h100) begin $display("FAIL empty_pp_count got %h exp %h", d, 32'h100); fails++; end
    for (int i = 0; i < 15; i++) push(8'h60 + 8'(i));
    wr(2'd1, 32'h4, 1, 8'hEE);
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1006) begin $display("FAIL ovf_set_wins got %h exp %h", d, 32'h1006); fails++; end
    wr(2'd3, 32'h0, 1, 8'hEE);
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h1) begin $display("FAIL drop_clr_race got %h exp 1", d); fails++; end
    rd(2'd0, 0, 0, d); tests++;
    if (d !== 32'h77) begin $display("FAIL boundary_head got %h exp 77", d); fails++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(2'd2, 32'h1, 0, 0);
    push(8'h11); tests++;
    if (irq !== 1'b1) begin $display("FAIL rstmid_irq_pre got %b exp 1", irq); fails++; end
    reset = 1; key_valid = 1; key_code = 8'h22;
    tick();
    reset = 0; key_valid = 0; tests++;
    if (irq !== 1'b0) begin $display("FAIL rstmid_irq got %b exp 0", irq); fails++; end
    rd(2'd1, 0, 0, d); tests++;
    if (d !== 32'h1) begin $display("FAIL rstmid_status got %h exp 1", d); fails++; end
    rd(2'd2, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL rstmid_ctrl got %h exp 0", d); fails++; end
    rd(2'd3, 0, 0, d); tests++;
    if (d !== 32'h0) begin $display("FAIL rstmid_drops got %h exp 0", d); fails++; end
    rd(2'd0, 0, 0, d); tests++;
    if (d !== 32'h8000_0000) begin $display("FAIL rstmid_data got %h exp %h", d, 32'h8000_0000); fails++; end
  endtask

  initial begin
    idle(); key_code = 0; reset = 1;
    #1;
    test_reset();
    test_order();
    test_overflow();
    test_full_pushpop();
    test_irq();
    test_flush();
    test_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
